// File: rtl/spi_apb_arbiter_pkg.sv
// spi_apb_arbiter_pkg
//   Shared definitions for the two-master APB arbiter in front of the SPI/flash
//   bridge: APB field widths, arbiter state encoding, master index constants
//   and the packed request record latched at grant time.
package spi_apb_arbiter_pkg;

  // APB widths, kept identical to the SoC-wide AMBA definitions.
  localparam int P_ADDR_W = 32;
  localparam int P_DATA_W = 32;
  localparam int P_STRB_W = P_DATA_W / 8;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_SETUP  = 2'd1,
    ARB_ACCESS = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_e;

  // Master index: 0 is instruction fetch (XIP), 1 is the data/LSU path.
  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  // Request fields captured from the winning master.
  typedef struct packed {
    logic [P_ADDR_W-1:0] addr;
    logic [2:0]          prot;
    logic                write;
    logic [P_DATA_W-1:0] wdata;
    logic [P_STRB_W-1:0] strb;
  } apb_req_t;

endpackage

// File: rtl/spi_arb_pick.sv
// spi_arb_pick
//   Combinational two-way picker. With rr_en set, a tie goes to the master
//   that was not served last; otherwise master 0 always wins a tie.
//   Ports:
//     req[1:0]    request per master (bit i = master i)
//     last_grant  master served by the most recent completed transfer
//     rr_en       1 = round-robin on ties, 0 = fixed priority
//     valid       at least one request present
//     winner      index of the selected master
module spi_arb_pick
  import spi_apb_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       rr_en,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = M_IFU;
    case (req)
      2'b01:   winner = M_IFU;
      2'b10:   winner = M_LSU;
      2'b11:   winner = rr_en ? ~last_grant : M_IFU;
      default: winner = M_IFU;
    endcase
  end

endmodule

// File: rtl/spi_apb_arbiter.sv
// spi_apb_arbiter
//   Two-master to one-slave APB arbiter for the SPI/flash bridge. One complete
//   transfer is granted at a time because the bridge's command sequence cannot
//   be interleaved. The winner's request fields are latched at grant, so later
//   changes on the master side have no effect on the slave transfer.
//   Ports:
//     clk, resetn                 clock, asynchronous active-low reset
//     m0_* / m1_* (inputs)        master APB request (paddr, psel, penable,
//                                 pprot, pwrite, pwdata, pstrb)
//     m0_* / m1_* (outputs)       per-master pready, prdata, pslverr; zero
//                                 unless that master is completing
//     s_* (outputs)               APB request toward the bridge
//     s_pready/s_prdata/s_pslverr slave response
module spi_apb_arbiter
  import spi_apb_arbiter_pkg::*;
#(
  parameter bit RR_EN     = 1'b1,
  parameter bit INIT_LAST = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [P_ADDR_W-1:0] m0_paddr,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic [2:0]          m0_pprot,
  input  logic                m0_pwrite,
  input  logic [P_DATA_W-1:0] m0_pwdata,
  input  logic [P_STRB_W-1:0] m0_pstrb,
  output logic                m0_pready,
  output logic [P_DATA_W-1:0] m0_prdata,
  output logic                m0_pslverr,
  input  logic [P_ADDR_W-1:0] m1_paddr,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic [2:0]          m1_pprot,
  input  logic                m1_pwrite,
  input  logic [P_DATA_W-1:0] m1_pwdata,
  input  logic [P_STRB_W-1:0] m1_pstrb,
  output logic                m1_pready,
  output logic [P_DATA_W-1:0] m1_prdata,
  output logic                m1_pslverr,
  output logic [P_ADDR_W-1:0] s_paddr,
  output logic                s_psel,
  output logic                s_penable,
  output logic [2:0]          s_pprot,
  output logic                s_pwrite,
  output logic [P_DATA_W-1:0] s_pwdata,
  output logic [P_STRB_W-1:0] s_pstrb,
  input  logic                s_pready,
  input  logic [P_DATA_W-1:0] s_prdata,
  input  logic                s_pslverr
);

  arb_state_e state_q, state_d;
  logic       grant_q;
  logic       last_grant_q;
  apb_req_t   req_q;
  apb_req_t   m0_req, m1_req;
  logic       pick_valid, pick_winner;
  logic       complete;

  // Arbitration looks only at psel; the master's penable phase is irrelevant.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  assign m0_req = '{addr: m0_paddr, prot: m0_pprot, write: m0_pwrite,
                    wdata: m0_pwdata, strb: m0_pstrb};
  assign m1_req = '{addr: m1_paddr, prot: m1_pprot, write: m1_pwrite,
                    wdata: m1_pwdata, strb: m1_pstrb};

  spi_arb_pick u_pick (
    .req        ({m1_psel, m0_psel}),
    .last_grant (last_grant_q),
    .rr_en      (RR_EN),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant and request fields are captured only when leaving IDLE; last_grant
  // moves on completion so an aborted (reset) transfer does not count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_q      <= M_IFU;
      last_grant_q <= INIT_LAST;
      req_q        <= '0;
    end else begin
      if (state_q == ARB_IDLE && pick_valid) begin
        grant_q <= pick_winner;
        req_q   <= pick_winner ? m1_req : m0_req;
      end
      if (complete) begin
        last_grant_q <= grant_q;
      end
    end
  end

  // s_pready is honoured only in ACCESS; a stray ready during SETUP is ignored.
  assign complete = (state_q == ARB_ACCESS) && s_pready;

  // DONE drops psel for one cycle so the bridge idles and the finished master
  // has released psel before the next arbitration in IDLE.
  always_comb begin
    state_d    = state_q;
    s_psel     = 1'b0;
    s_penable  = 1'b0;
    m0_pready  = 1'b0;
    m0_prdata  = '0;
    m0_pslverr = 1'b0;
    m1_pready  = 1'b0;
    m1_prdata  = '0;
    m1_pslverr = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) state_d = ARB_SETUP;
      end
      ARB_SETUP: begin
        s_psel  = 1'b1;
        state_d = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        s_psel    = 1'b1;
        s_penable = 1'b1;
        if (s_pready) state_d = ARB_DONE;
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    // Response is routed only to the granted master; the other port stays 0.
    if (complete && grant_q == M_IFU) begin
      m0_pready  = 1'b1;
      m0_prdata  = s_prdata;
      m0_pslverr = s_pslverr;
    end
    if (complete && grant_q == M_LSU) begin
      m1_pready  = 1'b1;
      m1_prdata  = s_prdata;
      m1_pslverr = s_pslverr;
    end
  end

  assign s_paddr  = req_q.addr;
  assign s_pprot  = req_q.prot;
  assign s_pwrite = req_q.write;
  assign s_pwdata = req_q.wdata;
  assign s_pstrb  = req_q.strb;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// tb_spi_apb_arbiter
//   Directed bench for spi_apb_arbiter. Two instances share the master and
//   slave stimulus: u_rr (round-robin) and u_fp (fixed priority); use_fp picks
//   which instance's outputs the master/slave models and checks observe.
//   Master models replay queued requests as APB masters; the slave model
//   answers after slave_wait wait states; a monitor logs every completion.
module tb_spi_apb_arbiter;
  import spi_apb_arbiter_pkg::*;

  typedef struct packed {
    logic [P_ADDR_W-1:0] addr;
    logic                wr;
    logic [P_DATA_W-1:0] wdata;
    logic [P_STRB_W-1:0] strb;
    logic                abort;
    logic                corrupt;
  } mreq_t;

  typedef struct packed {
    logic                p0;
    logic                p1;
    logic [P_ADDR_W-1:0] addr;
    logic                wr;
    logic [P_DATA_W-1:0] wdata;
    logic [P_STRB_W-1:0] strb;
    logic [P_DATA_W-1:0] rd0;
    logic [P_DATA_W-1:0] rd1;
    logic                err0;
    logic                err1;
    int                  lat;
  } rec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic use_fp = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Master-side drive
  logic                mpsel [2];
  logic                mpen  [2];
  logic [P_ADDR_W-1:0] mpaddr[2];
  logic [2:0]          mpprot[2];
  logic                mpwr  [2];
  logic [P_DATA_W-1:0] mpwdat[2];
  logic [P_STRB_W-1:0] mpstrb[2];

  // Slave-side drive
  logic                s_pready = 1'b0;
  logic [P_DATA_W-1:0] s_prdata = '0;
  logic                s_pslverr = 1'b0;
  int                  slave_wait = 0;
  logic [P_DATA_W-1:0] slave_rdata = '0;
  logic                slave_err = 1'b0;

  // Per-instance outputs
  wire                a_m0_pready, a_m0_pslverr, a_m1_pready, a_m1_pslverr;
  wire [P_DATA_W-1:0] a_m0_prdata, a_m1_prdata, a_s_pwdata;
  wire [P_ADDR_W-1:0] a_s_paddr;
  wire                a_s_psel, a_s_penable, a_s_pwrite;
  wire [2:0]          a_s_pprot;
  wire [P_STRB_W-1:0] a_s_pstrb;
  wire                b_m0_pready, b_m0_pslverr, b_m1_pready, b_m1_pslverr;
  wire [P_DATA_W-1:0] b_m0_prdata, b_m1_prdata, b_s_pwdata;
  wire [P_ADDR_W-1:0] b_s_paddr;
  wire                b_s_psel, b_s_penable, b_s_pwrite;
  wire [2:0]          b_s_pprot;
  wire [P_STRB_W-1:0] b_s_pstrb;

  spi_apb_arbiter #(.RR_EN(1'b1), .INIT_LAST(1'b1)) u_rr (
    .clk(clk), .resetn(resetn),
    .m0_paddr(mpaddr[0]), .m0_psel(mpsel[0]), .m0_penable(mpen[0]), .m0_pprot(mpprot[0]),
    .m0_pwrite(mpwr[0]), .m0_pwdata(mpwdat[0]), .m0_pstrb(mpstrb[0]),
    .m0_pready(a_m0_pready), .m0_prdata(a_m0_prdata), .m0_pslverr(a_m0_pslverr),
    .m1_paddr(mpaddr[1]), .m1_psel(mpsel[1]), .m1_penable(mpen[1]), .m1_pprot(mpprot[1]),
    .m1_pwrite(mpwr[1]), .m1_pwdata(mpwdat[1]), .m1_pstrb(mpstrb[1]),
    .m1_pready(a_m1_pready), .m1_prdata(a_m1_prdata), .m1_pslverr(a_m1_pslverr),
    .s_paddr(a_s_paddr), .s_psel(a_s_psel), .s_penable(a_s_penable), .s_pprot(a_s_pprot),
    .s_pwrite(a_s_pwrite), .s_pwdata(a_s_pwdata), .s_pstrb(a_s_pstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr)
  );

  spi_apb_arbiter #(.RR_EN(1'b0), .INIT_LAST(1'b1)) u_fp (
    .clk(clk), .resetn(resetn),
    .m0_paddr(mpaddr[0]), .m0_psel(mpsel[0]), .m0_penable(mpen[0]), .m0_pprot(mpprot[0]),
    .m0_pwrite(mpwr[0]), .m0_pwdata(mpwdat[0]), .m0_pstrb(mpstrb[0]),
    .m0_pready(b_m0_pready), .m0_prdata(b_m0_prdata), .m0_pslverr(b_m0_pslverr),
    .m1_paddr(mpaddr[1]), .m1_psel(mpsel[1]), .m1_penable(mpen[1]), .m1_pprot(mpprot[1]),
    .m1_pwrite(mpwr[1]), .m1_pwdata(mpwdat[1]), .m1_pstrb(mpstrb[1]),
    .m1_pready(b_m1_pready), .m1_prdata(b_m1_prdata), .m1_pslverr(b_m1_pslverr),
    .s_paddr(b_s_paddr), .s_psel(b_s_psel), .s_penable(b_s_penable), .s_pprot(b_s_pprot),
    .s_pwrite(b_s_pwrite), .s_pwdata(b_s_pwdata), .s_pstrb(b_s_pstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr)
  );

  // Observed instance
  wire                m0_pready  = use_fp ? b_m0_pready  : a_m0_pready;
  wire [P_DATA_W-1:0] m0_prdata  = use_fp ? b_m0_prdata  : a_m0_prdata;
  wire                m0_pslverr = use_fp ? b_m0_pslverr : a_m0_pslverr;
  wire                m1_pready  = use_fp ? b_m1_pready  : a_m1_pready;
  wire [P_DATA_W-1:0] m1_prdata  = use_fp ? b_m1_prdata  : a_m1_prdata;
  wire                m1_pslverr = use_fp ? b_m1_pslverr : a_m1_pslverr;
  wire [P_ADDR_W-1:0] s_paddr    = use_fp ? b_s_paddr    : a_s_paddr;
  wire                s_psel     = use_fp ? b_s_psel     : a_s_psel;
  wire                s_penable  = use_fp ? b_s_penable  : a_s_penable;
  wire [2:0]          s_pprot    = use_fp ? b_s_pprot    : a_s_pprot;
  wire                s_pwrite   = use_fp ? b_s_pwrite   : a_s_pwrite;
  wire [P_DATA_W-1:0] s_pwdata   = use_fp ? b_s_pwdata   : a_s_pwdata;
  wire [P_STRB_W-1:0] s_pstrb    = use_fp ? b_s_pstrb    : a_s_pstrb;

  // Request queues: tail written by the test tasks, head by the master model.
  mreq_t mq[2][64];
  int    tail[2] = '{0, 0};
  int    head[2] = '{0, 0};
  int    mst[2] = '{0, 0};
  logic  mdone[2] = '{1'b0, 1'b0};
  logic  cur_abort[2] = '{1'b0, 1'b0};
  logic  cur_corrupt[2] = '{1'b0, 1'b0};
  int    start_cyc[2] = '{0, 0};

  task automatic master_load(input int i);
    mreq_t r;
    if (head[i] != tail[i]) begin
      r = mq[i][head[i] % 64];
      head[i]++;
      mpaddr[i] = r.addr;
      mpwr[i] = r.wr;
      mpwdat[i] = r.wdata;
      mpstrb[i] = r.strb;
      mpprot[i] = 3'b000;
      cur_abort[i] = r.abort;
      cur_corrupt[i] = r.corrupt;
      mpsel[i] = 1'b1;
      mpen[i] = 1'b0;
      mst[i] = 1;
      start_cyc[i] = cyc;
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      mpsel[i] = 1'b0; mpen[i] = 1'b0; mpaddr[i] = '0; mpprot[i] = '0;
      mpwr[i] = 1'b0; mpwdat[i] = '0; mpstrb[i] = '0;
    end
  end

  // APB master models: setup, access until pready, then next queued request.
  always begin
    @(negedge clk);
    mdone[0] = m0_pready;
    mdone[1] = m1_pready;
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!resetn) begin
        mpsel[i] = 1'b0; mpen[i] = 1'b0; mst[i] = 0; head[i] = tail[i];
      end else if (mst[i] == 0) begin
        master_load(i);
      end else if (mst[i] == 1) begin
        if (cur_abort[i]) begin
          mpsel[i] = 1'b0; mpen[i] = 1'b0; mst[i] = 0;
        end else begin
          mpen[i] = 1'b1;
          if (cur_corrupt[i]) begin
            mpwdat[i] = '0;
            mpaddr[i] = ~mpaddr[i];
          end
          mst[i] = 2;
        end
      end else if (mdone[i]) begin
        mpsel[i] = 1'b0; mpen[i] = 1'b0; mst[i] = 0;
        master_load(i);
      end
    end
  end

  // Slave model: ready after slave_wait access cycles.
  int s_cnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (!resetn) begin
      s_cnt = 0; s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
    end else if (s_psel && s_penable && !s_pready) begin
      if (s_cnt >= slave_wait) begin
        s_pready = 1'b1; s_prdata = slave_rdata; s_pslverr = slave_err; s_cnt = 0;
      end else begin
        s_cnt++;
      end
    end else begin
      s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
    end
  end

  // Completion monitor
  rec_t recs[$];
  int   pulse0 = 0, pulse1 = 0, setup_cnt = 0, leak_cnt = 0;
  logic [P_ADDR_W-1:0] setup_addr = '0;
  always @(negedge clk) begin : mon
    rec_t r;
    if (resetn) begin
      if (s_psel && s_penable && s_pready) begin
        r.p0 = m0_pready; r.p1 = m1_pready; r.addr = s_paddr; r.wr = s_pwrite;
        r.wdata = s_pwdata; r.strb = s_pstrb; r.rd0 = m0_prdata; r.rd1 = m1_prdata;
        r.err0 = m0_pslverr; r.err1 = m1_pslverr;
        r.lat = cyc - (m1_pready ? start_cyc[1] : start_cyc[0]);
        recs.push_back(r);
      end
      if (s_psel && !s_penable) begin
        setup_cnt++;
        setup_addr = s_paddr;
      end
      if (m0_pready) pulse0++;
      if (m1_pready) pulse1++;
      if ((m0_pready && m1_pready) ||
          (!m0_pready && (m0_prdata != '0 || m0_pslverr)) ||
          (!m1_pready && (m1_prdata != '0 || m1_pslverr)))
        leak_cnt++;
    end
  end

  task automatic push(input int m, input logic [P_ADDR_W-1:0] addr, input logic wr,
                      input logic [P_DATA_W-1:0] wdata, input logic [P_STRB_W-1:0] strb,
                      input logic abort, input logic corrupt);
    mq[m][tail[m] % 64] = '{addr: addr, wr: wr, wdata: wdata, strb: strb,
                            abort: abort, corrupt: corrupt};
    tail[m]++;
  endtask

  task automatic wait_recs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #1;
      if (recs.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    use_fp = 1'b0;
    apply_reset();
    checks++;
    if ({s_psel, s_penable, s_paddr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_slave_side: got psel=%b penable=%b paddr=%h, expected all 0", s_psel, s_penable, s_paddr);
    end
    checks++;
    if ({m0_pready, m0_prdata, m0_pslverr, m1_pready, m1_prdata, m1_pslverr} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_master_side: got m0_pready=%b m1_pready=%b, expected all 0", m0_pready, m1_pready);
    end
  endtask

  task automatic test_single_read();
    int base, s0, p0, p1, lk;
    bit ok;
    use_fp = 1'b0;
    apply_reset();
    slave_wait = 5; slave_rdata = 32'hDEADBEEF; slave_err = 1'b0;
    base = recs.size(); s0 = setup_cnt; p0 = pulse0; p1 = pulse1; lk = leak_cnt;
    push(0, 32'h3000_0010, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_recs(base + 1, 40, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL single_read_timeout: got no completion, expected one within 40 cycles");
    end else begin
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (recs[base].rd0 !== 32'hDEADBEEF) begin
        errors++; $display("[TB] FAIL single_read_prdata: got %h expected deadbeef", recs[base].rd0);
      end
      checks++;
      if ({recs[base].addr, recs[base].wr} !== {32'h3000_0010, 1'b0}) begin
        errors++; $display("[TB] FAIL single_read_addr: got %h/%b expected 30000010/0", recs[base].addr, recs[base].wr);
      end
      checks++;
      if (recs[base].lat !== 7) begin
        errors++; $display("[TB] FAIL single_read_latency: got %0d expected 7", recs[base].lat);
      end
      checks++;
      if ({pulse0 - p0, pulse1 - p1} !== {32'd1, 32'd0}) begin
        errors++; $display("[TB] FAIL single_read_pulses: got m0=%0d m1=%0d expected 1/0", pulse0 - p0, pulse1 - p1);
      end
      checks++;
      if ({setup_cnt - s0, leak_cnt - lk} !== {32'd1, 32'd0}) begin
        errors++; $display("[TB] FAIL single_read_setup_leak: got setups=%0d leaks=%0d expected 1/0", setup_cnt - s0, leak_cnt - lk);
      end
      checks++;
      if (setup_addr !== 32'h3000_0010) begin
        errors++; $display("[TB] FAIL single_read_setup_addr: got %h expected 30000010", setup_addr);
      end
    end
  endtask

  task automatic test_round_robin();
    int base;
    bit ok;
    use_fp = 1'b0;
    apply_reset();
    slave_wait = 0; slave_rdata = 32'h0; slave_err = 1'b0;
    base = recs.size();
    push(0, 32'h3000_0100, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    push(1, 32'h3000_0200, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_recs(base + 2, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL rr_pair1_timeout: got %0d completions expected 2", recs.size() - base);
      return;
    end
    checks++;
    if ({recs[base].p0, recs[base].addr} !== {1'b1, 32'h3000_0100}) begin
      errors++; $display("[TB] FAIL rr_pair1_first: got p0=%b addr=%h expected 1/30000100", recs[base].p0, recs[base].addr);
    end
    checks++;
    if ({recs[base+1].p1, recs[base+1].addr} !== {1'b1, 32'h3000_0200}) begin
      errors++; $display("[TB] FAIL rr_pair1_second: got p1=%b addr=%h expected 1/30000200", recs[base+1].p1, recs[base+1].addr);
    end
    // A solo master-0 transfer leaves last_grant at 0, so the next tie is master 1's.
    push(0, 32'h3000_0300, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_recs(base + 3, 40, ok);
    push(0, 32'h3000_0400, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    push(1, 32'h3000_0500, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_recs(base + 5, 60, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL rr_pair2_timeout: got %0d completions expected 5", recs.size() - base);
      return;
    end
    checks++;
    if ({recs[base+3].p1, recs[base+3].addr, recs[base+4].p0, recs[base+4].addr} !==
        {1'b1, 32'h3000_0500, 1'b1, 32'h3000_0400}) begin
      errors++; $display("[TB] FAIL rr_pair2_order: got first=%h second=%h expected 30000500 then 30000400", recs[base+3].addr, recs[base+4].addr);
    end
  endtask

  task automatic test_fixed_priority();
    int base;
    bit ok;
    logic [7:0] order;
    logic [P_ADDR_W-1:0] exp_addr;
    use_fp = 1'b1;
    apply_reset();
    slave_wait = 1; slave_rdata = 32'h0; slave_err = 1'b0;
    base = recs.size();
    for (int i = 0; i < 4; i++) begin
      push(0, 32'h3000_1000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
      push(1, 32'h1000_2000 + 32'(4 * i), 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    end
    wait_recs(base + 8, 200, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL fp_timeout: got %0d completions expected 8", recs.size() - base);
    end else begin
      order = '0;
      for (int i = 0; i < 8; i++) order[i] = recs[base+i].p1;
      checks++;
      if (order !== 8'hF0) begin
        errors++; $display("[TB] FAIL fp_order: got %b expected 11110000", order);
      end
      for (int i = 0; i < 8; i++) begin
        exp_addr = (i < 4) ? 32'h3000_1000 + 32'(4 * i) : 32'h1000_2000 + 32'(4 * (i - 4));
        checks++;
        if (recs[base+i].addr !== exp_addr) begin
          errors++; $display("[TB] FAIL fp_addr_%0d: got %h expected %h", i, recs[base+i].addr, exp_addr);
        end
      end
    end
    apply_reset();
    use_fp = 1'b0;
  endtask

  task automatic test_csr_write();
    int base;
    bit ok;
    use_fp = 1'b0;
    apply_reset();
    slave_wait = 2; slave_rdata = 32'h0000_55AA; slave_err = 1'b1;
    base = recs.size();
    push(1, 32'h1000_1010, 1'b1, 32'h0000_1234, 4'hF, 1'b0, 1'b1);
    wait_recs(base + 1, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL csr_timeout: got no completion expected one");
      return;
    end
    checks++;
    if ({recs[base].addr, recs[base].wr, recs[base].wdata, recs[base].strb} !==
        {32'h1000_1010, 1'b1, 32'h0000_1234, 4'hF}) begin
      errors++; $display("[TB] FAIL csr_latched_fields: got addr=%h wr=%b wdata=%h strb=%h expected 10001010/1/00001234/f",
                         recs[base].addr, recs[base].wr, recs[base].wdata, recs[base].strb);
    end
    checks++;
    if ({recs[base].p1, recs[base].err1, recs[base].rd1, recs[base].p0, recs[base].err0} !==
        {1'b1, 1'b1, 32'h0000_55AA, 1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL csr_response: got p1=%b err1=%b rd1=%h p0=%b err0=%b expected 1/1/000055aa/0/0",
                         recs[base].p1, recs[base].err1, recs[base].rd1, recs[base].p0, recs[base].err0);
    end
    slave_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int base;
    bit ok;
    use_fp = 1'b0;
    apply_reset();
    slave_wait = 20; slave_rdata = 32'h1111_2222; slave_err = 1'b0;
    push(0, 32'h3000_0020, 1'b1, 32'hCAFE_F00D, 4'h3, 1'b0, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (s_penable) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL reset_mid_no_access: got s_penable=0 expected access phase");
      return;
    end
    #1;
    resetn = 1'b0;
    #1;
    checks++;
    if ({s_psel, s_penable, s_paddr, s_pwrite, s_pwdata, s_pstrb, s_pprot} !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_slave: got psel=%b penable=%b paddr=%h wdata=%h expected all 0", s_psel, s_penable, s_paddr, s_pwdata);
    end
    checks++;
    if ({m0_pready, m0_prdata, m0_pslverr, m1_pready, m1_prdata, m1_pslverr} !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_master: got m0_pready=%b m1_pready=%b expected 0", m0_pready, m1_pready);
    end
    repeat (2) @(negedge clk);
    #2;
    resetn = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (s_psel !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_mid_idle: got s_psel=%b expected 0", s_psel);
    end
    slave_wait = 0;
    base = recs.size();
    push(0, 32'h3000_0030, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    push(1, 32'h3000_0040, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_recs(base + 2, 40, ok);
    checks++;
    if (!ok || recs[base].p0 !== 1'b1 || recs[base].addr !== 32'h3000_0030) begin
      errors++; $display("[TB] FAIL reset_mid_first_tie: got ok=%b p0=%b expected master 0 first", ok, ok ? recs[base].p0 : 1'b0);
    end
  endtask

  task automatic test_drop_psel();
    int base;
    bit ok;
    use_fp = 1'b0;
    apply_reset();
    slave_wait = 0; slave_rdata = 32'h0; slave_err = 1'b0;
    base = recs.size();
    push(0, 32'h3000_0050, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    push(1, 32'h1000_0060, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    wait_recs(base + 2, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("[TB] FAIL drop_timeout: got %0d completions expected 2", recs.size() - base);
      return;
    end
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if ({recs[base].p0, recs[base].addr} !== {1'b1, 32'h3000_0050}) begin
      errors++; $display("[TB] FAIL drop_latched: got p0=%b addr=%h expected 1/30000050", recs[base].p0, recs[base].addr);
    end
    checks++;
    if ({recs[base+1].p1, recs[base+1].addr} !== {1'b1, 32'h1000_0060}) begin
      errors++; $display("[TB] FAIL drop_next_m1: got p1=%b addr=%h expected 1/10000060", recs[base+1].p1, recs[base+1].addr);
    end
    checks++;
    if (recs.size() - base !== 2) begin
      errors++; $display("[TB] FAIL drop_no_regrant: got %0d completions expected 2", recs.size() - base);
    end
  endtask

  initial begin
    $display("[TB] starting spi_apb_arbiter bench");
    test_reset();
    test_single_read();
    test_round_robin();
    test_fixed_priority();
    test_csr_write();
    test_reset_mid();
    test_drop_psel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
